xadc_drp_sampler: RTL and testbench

//  DRP initiator for the XADC wizard instance running a continuous sequence on VAUX4/VAUX12.
//  Per EOS pulse: reads both result registers over DRP, presents the pair as one sample
//  on a valid/ready stream to downstream logic (current/voltage processing).

---
 rtl/xadc_drp_sampler_pkg.sv | 26 ++
 rtl/xadc_drp_sampler.sv | 139 +++++++++++++
 tb/tb_xadc_drp_sampler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_sampler_pkg.sv
// xadc_pkg: shared constants and types for the XADC DRP sampler.
//   XADC_VAUX4_ADDR / XADC_VAUX12_ADDR : DRP result register addresses
//   XADC_CODE_W                        : width of an XADC conversion code
//   XADC_DRDY_TIMEOUT                  : default drdy wait limit in dclk cycles
//   xadc_sampler_state_t               : sampler FSM states
//   xadc_sample_t                      : one published (current, voltage) pair
package xadc_pkg;
  localparam logic [6:0] XADC_VAUX4_ADDR   = 7'h14;
  localparam logic [6:0] XADC_VAUX12_ADDR  = 7'h1C;
  localparam int         XADC_CODE_W       = 12;
  localparam int         XADC_DRDY_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_A,
    ST_WAIT_A,
    ST_REQ_B,
    ST_WAIT_B,
    ST_PUBLISH
  } xadc_sampler_state_t;

  typedef struct packed {
    logic [XADC_CODE_W-1:0] code_a;
    logic [XADC_CODE_W-1:0] code_b;
  } xadc_sample_t;
endpackage

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: read-only DRP initiator for an XADC running a continuous
// VAUX4/VAUX12 sequence. Each EOS triggers a read of both result registers;
// the pair is published on a valid/ready stream through a one-entry output reg.
// Ports:
//   dclk_in, reset_n_in          : DRP clock, async active-low reset
//   eos_in                       : end-of-sequence pulse
//   den_out/dwe_out/daddr_out/di_out/drdy_in/do_in : DRP master (reads only)
//   sample_a_out/sample_b_out    : VAUX4 / VAUX12 12-bit codes
//   sample_valid_out/sample_ready_in : output stream handshake
//   overrun_out                  : pulse, completed pair dropped (output reg full)
//   timeout_out                  : pulse, drdy never came back
//   busy_out                     : read sequence in flight
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter logic [6:0] CH_A_ADDR    = XADC_VAUX4_ADDR,
  parameter logic [6:0] CH_B_ADDR    = XADC_VAUX12_ADDR,
  parameter int         DRDY_TIMEOUT = XADC_DRDY_TIMEOUT
) (
  input  logic        dclk_in,
  input  logic        reset_n_in,
  input  logic        eos_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [11:0] sample_a_out,
  output logic [11:0] sample_b_out,
  output logic        sample_valid_out,
  input  logic        sample_ready_in,
  output logic        overrun_out,
  output logic        timeout_out,
  output logic        busy_out
);
  localparam int TW = $clog2(DRDY_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_MAX  = '1;
  localparam logic [TW-1:0] T_LAST = TW'(DRDY_TIMEOUT - 1);

  xadc_sampler_state_t r_state;
  logic                r_eos_pending;
  logic [TW-1:0]       r_timer;
  logic                r_den;
  logic [6:0]          r_daddr;
  logic                r_overrun;
  logic                r_timeout;
  logic                r_valid;
  xadc_sample_t        r_shadow;
  xadc_sample_t        r_sample;

  // Low nibble of the DRP result is below XADC code resolution.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^do_in[3:0];

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state       <= ST_IDLE;
      r_eos_pending <= 1'b0;
      r_timer       <= '0;
      r_den         <= 1'b0;
      r_daddr       <= '0;
      r_overrun     <= 1'b0;
      r_timeout     <= 1'b0;
      r_valid       <= 1'b0;
      r_shadow      <= '0;
      r_sample      <= '0;
    end else begin
      r_den     <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (r_valid && sample_ready_in) r_valid <= 1'b0;
      // EOS while busy is remembered once; more pulses merge into it.
      if (eos_in && r_state != ST_IDLE) r_eos_pending <= 1'b1;
      // Timer counts dclk cycles since den (zero in the REQ cycle), saturating.
      if (r_timer != T_MAX) r_timer <= r_timer + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (eos_in || r_eos_pending) begin
            r_state       <= ST_REQ_A;
            r_eos_pending <= 1'b0;
            r_den         <= 1'b1;
            r_daddr       <= CH_A_ADDR;
            r_timer       <= '0;
          end
        end
        ST_REQ_A: r_state <= ST_WAIT_A;
        ST_WAIT_A: begin
          if (drdy_in) begin
            r_shadow.code_a <= do_in[15:4];
            r_state         <= ST_REQ_B;
            r_den           <= 1'b1;
            r_daddr         <= CH_B_ADDR;
            r_timer         <= '0;
          end else if (r_timer == T_LAST) begin
            r_timeout <= 1'b1;
            r_shadow  <= '0;
            r_state   <= ST_IDLE;
          end
        end
        ST_REQ_B: r_state <= ST_WAIT_B;
        ST_WAIT_B: begin
          if (drdy_in) begin
            r_shadow.code_b <= do_in[15:4];
            r_state         <= ST_PUBLISH;
          end else if (r_timer == T_LAST) begin
            r_timeout <= 1'b1;
            r_shadow  <= '0;
            r_state   <= ST_IDLE;
          end
        end
        ST_PUBLISH: begin
          // Load when the slot is free or draining this cycle; otherwise the
          // new pair is lost and the held one stays untouched.
          if (!r_valid || sample_ready_in) begin
            r_sample <= r_shadow;
            r_valid  <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign den_out          = r_den;
  assign dwe_out          = 1'b0;
  assign daddr_out        = r_daddr;
  assign di_out           = '0;
  assign sample_a_out     = r_sample.code_a;
  assign sample_b_out     = r_sample.code_b;
  assign sample_valid_out = r_valid;
  assign overrun_out      = r_overrun;
  assign timeout_out      = r_timeout;
  assign busy_out         = (r_state != ST_IDLE);
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler: DRP responder with configurable drdy
// latency, expected DRP addresses and sample pairs queued at stimulus time,
// monitor pops and compares on den_out and on valid&ready.
module tb_xadc_drp_sampler;
  import xadc_pkg::*;
  localparam int TO = 64;

  logic        dclk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        eos_in = 1'b0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = 16'hDEAD;
  logic        sample_ready_in = 1'b0;
  logic        den_out, dwe_out, sample_valid_out, overrun_out, timeout_out, busy_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic [11:0] sample_a_out, sample_b_out;

  xadc_drp_sampler dut (
    .dclk_in(dclk_in), .reset_n_in(reset_n_in), .eos_in(eos_in),
    .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
    .drdy_in(drdy_in), .do_in(do_in),
    .sample_a_out(sample_a_out), .sample_b_out(sample_b_out),
    .sample_valid_out(sample_valid_out), .sample_ready_in(sample_ready_in),
    .overrun_out(overrun_out), .timeout_out(timeout_out), .busy_out(busy_out)
  );

  always #5 dclk_in = ~dclk_in;

  int cyc = 0;
  always @(posedge dclk_in) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;
  logic [6:0]   exp_addr[$];
  xadc_sample_t exp_pair[$];

  // responder configuration
  int          lat = 1;
  bit          drop_b = 1'b0;
  logic [15:0] resp_a = 16'h0, resp_b = 16'h0;

  // monitor statistics
  int den_cnt = 0, pair_cnt = 0, ovr_cnt = 0, to_cnt = 0;
  int den_a_cyc = 0, den_b_cyc = 0, drdy_b_cyc = 0, to_cyc = 0, vrise_cyc = 0, eos_cyc = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  always @(negedge dclk_in) begin
    if (reset_n_in) begin
      if (den_out) begin
        den_cnt++;
        if (exp_addr.size() == 0) fail("den_unexpected", $sformatf("got den addr %0h, expected no read", daddr_out));
        else chk("daddr", 32'(daddr_out), 32'(exp_addr.pop_front()));
        chk("dwe_di_zero", {15'd0, dwe_out, di_out}, 32'd0);
        if (daddr_out == XADC_VAUX4_ADDR) den_a_cyc = cyc;
        else den_b_cyc = cyc;
      end
      if (sample_valid_out && !prev_valid) vrise_cyc = cyc;
      if (sample_valid_out && sample_ready_in) begin
        pair_cnt++;
        if (exp_pair.size() == 0) fail("pair_unexpected", $sformatf("got pair %0h/%0h, expected none", sample_a_out, sample_b_out));
        else begin
          xadc_sample_t e;
          e = exp_pair.pop_front();
          chk("pair_a", 32'(sample_a_out), 32'(e.code_a));
          chk("pair_b", 32'(sample_b_out), 32'(e.code_b));
        end
      end
      if (overrun_out) ovr_cnt++;
      if (timeout_out) begin
        to_cnt++;
        to_cyc = cyc;
      end
      prev_valid = sample_valid_out;
    end
  end

  // DRP responder: answers each den after 'lat' cycles with a one-cycle drdy.
  initial begin
    logic [6:0] a;
    forever begin
      @(negedge dclk_in);
      if (reset_n_in && den_out) begin
        a = daddr_out;
        if (!(drop_b && a == XADC_VAUX12_ADDR)) begin
          repeat (lat) @(posedge dclk_in);
          #1;
          drdy_in = 1'b1;
          do_in   = (a == XADC_VAUX4_ADDR) ? resp_a : resp_b;
          if (a == XADC_VAUX12_ADDR) drdy_b_cyc = cyc;
          @(posedge dclk_in);
          #1;
          drdy_in = 1'b0;
          do_in   = 16'hDEAD;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge dclk_in);
    #1;
  endtask

  task automatic pulse_eos();
    @(posedge dclk_in);
    #1 eos_in = 1'b1;
    eos_cyc = cyc;
    @(posedge dclk_in);
    #1 eos_in = 1'b0;
  endtask

  task automatic push_seq(input logic [15:0] a, input logic [15:0] b, input bit with_pair);
    xadc_sample_t p;
    resp_a = a;
    resp_b = b;
    exp_addr.push_back(XADC_VAUX4_ADDR);
    exp_addr.push_back(XADC_VAUX12_ADDR);
    if (with_pair) begin
      p.code_a = a[15:4];
      p.code_b = b[15:4];
      exp_pair.push_back(p);
    end
  endtask

  task automatic wait_pairs(input int target, input int limit);
    int n = 0;
    while (pair_cnt < target && n < limit) begin
      @(posedge dclk_in);
      n++;
    end
    #1;
    if (pair_cnt < target) fail("wait_pairs", $sformatf("got %0d pairs, expected %0d", pair_cnt, target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0, t0, d0, n;
    // reset state
    wait_cycles(3);
    @(negedge dclk_in);
    chk("rst_ctrl", {26'd0, den_out, dwe_out, sample_valid_out, overrun_out, timeout_out, busy_out}, 32'd0);
    chk("rst_daddr_di", {9'd0, daddr_out, di_out}, 32'd0);
    chk("rst_samples", {8'd0, sample_a_out, sample_b_out}, 32'd0);
    @(posedge dclk_in);
    #1 reset_n_in = 1'b1;
    wait_cycles(2);

    // 1: basic sequence and latencies
    lat = 1;
    sample_ready_in = 1'b1;
    push_seq(16'h07F0, 16'h0FF0, 1'b1);
    pulse_eos();
    wait_pairs(1, 50);
    chk("lat_eos_den", 32'(den_a_cyc - eos_cyc), 32'd1);
    chk("lat_denA_denB", 32'(den_b_cyc - den_a_cyc), 32'd2);
    chk("lat_drdy_valid", 32'(vrise_cyc - drdy_b_cyc), 32'd2);
    @(negedge dclk_in);
    chk("valid_one_cycle", 32'(sample_valid_out), 32'd0);

    // 2: output held while not ready, second pair overruns
    sample_ready_in = 1'b0;
    p0 = pair_cnt;
    push_seq(16'h1230, 16'h4560, 1'b1);
    pulse_eos();
    n = 0;
    while (!sample_valid_out && n < 30) begin
      @(posedge dclk_in);
      n++;
    end
    #1;
    chk("held_valid", 32'(sample_valid_out), 32'd1);
    o0 = ovr_cnt;
    push_seq(16'hABC5, 16'hDEFA, 1'b0);
    pulse_eos();
    wait_cycles(30);
    chk("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("held_pair", {8'd0, sample_a_out, sample_b_out}, {8'd0, 12'h123, 12'h456});
    chk("held_valid_still", 32'(sample_valid_out), 32'd1);
    sample_ready_in = 1'b1;
    wait_pairs(p0 + 1, 10);
    wait_cycles(10);
    chk("no_second_valid", 32'(pair_cnt - p0), 32'd1);
    chk("q_empty_2", 32'(exp_pair.size()), 32'd0);

    // 3: CH_B never answers -> timeout, then normal recovery
    drop_b = 1'b1;
    t0 = to_cnt;
    p0 = pair_cnt;
    push_seq(16'h1110, 16'h2220, 1'b0);
    pulse_eos();
    n = 0;
    while (to_cnt == t0 && n < 200) begin
      @(posedge dclk_in);
      n++;
    end
    #1;
    chk("timeout_pulses", 32'(to_cnt - t0), 32'd1);
    // den in cycle c, timeout_out visible in cycle c+DRDY_TIMEOUT
    chk("timeout_latency", 32'(to_cyc - den_b_cyc), 32'(TO));
    chk("timeout_no_pair", 32'(pair_cnt - p0), 32'd0);
    chk("timeout_busy", 32'(busy_out), 32'd0);
    drop_b = 1'b0;
    push_seq(16'h0013, 16'hFFF0, 1'b1);
    pulse_eos();
    wait_pairs(p0 + 1, 50);

    // 4: two EOS during WAIT_A merge into one extra sequence
    lat = 8;
    p0 = pair_cnt;
    d0 = den_cnt;
    push_seq(16'h5550, 16'hAAA0, 1'b1);
    push_seq(16'h5550, 16'hAAA0, 1'b1);
    pulse_eos();
    pulse_eos();
    pulse_eos();
    wait_pairs(p0 + 2, 200);
    wait_cycles(40);
    chk("merge_pairs", 32'(pair_cnt - p0), 32'd2);
    chk("merge_dens", 32'(den_cnt - d0), 32'd4);
    chk("merge_idle", 32'(busy_out), 32'd0);

    // 5: reset during WAIT_B, late drdy ignored
    lat = 10;
    p0 = pair_cnt;
    d0 = den_cnt;
    push_seq(16'h7770, 16'h8880, 1'b0);
    pulse_eos();
    n = 0;
    while (den_cnt < d0 + 2 && n < 50) begin
      @(posedge dclk_in);
      n++;
    end
    wait_cycles(2);
    reset_n_in = 1'b0;
    @(negedge dclk_in);
    chk("rst_mid_ctrl", {26'd0, den_out, dwe_out, sample_valid_out, overrun_out, timeout_out, busy_out}, 32'd0);
    chk("rst_mid_daddr", 32'(daddr_out), 32'd0);
    @(posedge dclk_in);
    #1 reset_n_in = 1'b1;
    wait_cycles(30);
    chk("rst_no_pair", 32'(pair_cnt - p0), 32'd0);
    chk("rst_no_read", 32'(den_cnt - d0), 32'd2);
    chk("rst_idle", {29'd0, busy_out, sample_valid_out, den_out}, 32'd0);
    chk("rst_samples_zero", {8'd0, sample_a_out, sample_b_out}, 32'd0);

    // 6: 100 back-to-back sequences with ready held high
    lat = 1;
    p0 = pair_cnt;
    o0 = ovr_cnt;
    t0 = to_cnt;
    for (int i = 0; i < 100; i++) begin
      logic [11:0] ca, cb;
      ca = 12'(i * 37 + 5);
      cb = 12'(4000 - i * 13);
      push_seq({ca, 4'(i)}, {cb, 4'(15 - (i % 16))}, 1'b1);
      pulse_eos();
      wait_cycles(18);
    end
    wait_pairs(p0 + 100, 100);
    chk("stream_pairs", 32'(pair_cnt - p0), 32'd100);
    chk("stream_overrun", 32'(ovr_cnt - o0), 32'd0);
    chk("stream_timeout", 32'(to_cnt - t0), 32'd0);
    chk("q_empty_end", 32'(exp_pair.size() + exp_addr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
